bench_bist_ctrl: RTL and testbench



---
 rtl/bist_pkg.sv | 29 ++
 rtl/bist_misr.sv | 31 +++
 rtl/bench_bist_ctrl.sv | 131 +++++++++++++
 tb/tb_bench_bist_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg
// Shared types, constants and next-state functions for the benchmark BIST
// wrappers: the sequencer state encoding, the 32-bit Fibonacci LFSR step
// (x^32+x^22+x^2+x+1) and the 16-bit MISR step (x^16+x^12+x^5+1).
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bist_state_t;

    localparam int              SIG_W     = 16;
    // Feedback taps at bits 31, 21, 1 and 0.
    localparam logic [31:0]     LFSR_TAPS = 32'h8020_0003;
    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

    // Shift left, new bit 0 is the XOR of the tapped bits.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m,
                                                   input logic [SIG_W-1:0] d);
        return {m[SIG_W-2:0], 1'b0} ^ (m[SIG_W-1] ? MISR_POLY : '0) ^ d;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr
// 16-bit multiple-input signature register. Clear has priority over enable.
// Ports:
//   clk    - clock
//   rst_n  - synchronous active-low reset
//   clr    - zero the signature on the next edge
//   en     - fold d into the signature on the next edge
//   d      - parallel data input (already zero-extended by the caller)
//   sig    - current signature
module bist_misr
    import bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [SIG_W-1:0] d,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_step(sig, d);
        end
    end

endmodule

// File: rtl/bench_bist_ctrl.sv
// bench_bist_ctrl
// BIST sequencer wrapped around one generated combinational benchmark.
// Drives the benchmark inputs from an LFSR for PATTERNS cycles, compacts the
// benchmark outputs into a MISR and compares the final signature with GOLDEN.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - one-cycle pulse, begins a run from IDLE or DONE
//   abort       - back to IDLE from any state, wins over start
//   dut_in      - benchmark input bus (low N_IN bits of the LFSR)
//   dut_out     - benchmark output bus
//   busy        - high in LOAD and RUN
//   done        - high in DONE
//   pass        - valid with done, signature matched GOLDEN
//   signature   - current MISR contents
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; LFSR, MISR and counter hold
// LOAD  | seed the LFSR, clear the MISR and pattern counter
// RUN   | one pattern per cycle: capture dut_out, advance LFSR, count
// DONE  | run complete; done/pass held until start or abort
module bench_bist_ctrl
    import bist_pkg::*;
#(
    parameter int          N_IN     = 26,
    parameter int          N_OUT    = 14,
    parameter int          PATTERNS = 1024,
    parameter logic [31:0] SEED     = 32'h0000_0001,
    parameter logic [15:0] GOLDEN   = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  dut_in,
    input  logic [N_OUT-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int          CW       = $clog2(PATTERNS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PATTERNS - 1);
    // An all-zero seed would lock the LFSR up, so it is replaced by 1.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    bist_state_t      state;
    logic [31:0]      lfsr;
    logic [CW-1:0]    cnt;
    logic [SIG_W-1:0] misr_d;
    logic             misr_clr;
    logic             misr_en;

    always_comb begin
        misr_d              = '0;
        misr_d[N_OUT-1:0]   = dut_out;
    end

    // Abort freezes the MISR in the cycle it is seen, same as the LFSR.
    assign misr_clr = (state == LOAD) && !abort;
    assign misr_en  = (state == RUN)  && !abort;

    assign dut_in = lfsr[N_IN-1:0];

    bist_misr u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .d     (misr_d),
        .sig   (signature)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            lfsr  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    lfsr  <= SEED_EFF;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    lfsr <= lfsr_step(lfsr);
                    cnt  <= cnt + CW'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Compare against the signature this final capture
                        // produces so pass is valid as done rises.
                        pass  <= (misr_step(signature, misr_d) == GOLDEN);
                    end
                end
                DONE: begin
                    if (start) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        pass  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bench_bist_ctrl.sv
// tb_bench_bist_ctrl
// Directed bench for bench_bist_ctrl. Four instances cover the default
// configuration, a single-pattern run, a short run with a hand-computed
// GOLDEN, and a zero SEED. All sampling and driving happens on negedge.
module tb_bench_bist_ctrl;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Stand-in benchmark: each output is the XOR of two input bits.
    function automatic logic [13:0] bench_f(input logic [25:0] x, input logic stuck8);
        logic [13:0] f;
        f = x[13:0] ^ x[25:12];
        if (stuck8) f[8] = 1'b0;
        return f;
    endfunction

    function automatic logic [31:0] model_lfsr(input logic [31:0] seed, input int n);
        logic [31:0] l;
        l = (seed == 32'h0) ? 32'h1 : seed;
        for (int i = 0; i < n; i++) l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        return l;
    endfunction

    // mode 0: outputs tied low, 1: bench_f, 2: identity on the low 14 bits
    function automatic logic [15:0] model_sig(input logic [31:0] seed, input int n, input int mode);
        logic [31:0] l;
        logic [15:0] m;
        logic [13:0] f;
        logic        fb;
        l = (seed == 32'h0) ? 32'h1 : seed;
        m = 16'h0;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       f = 14'h0;
                1:       f = bench_f(l[25:0], 1'b0);
                default: f = l[13:0];
            endcase
            fb = m[15];
            m  = m << 1;
            if (fb) m = m ^ 16'h1021;
            m = m ^ {2'b00, f};
            l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
        end
        return m;
    endfunction

    // ---------------- instance A: defaults ----------------
    logic        a_start, a_abort, a_busy, a_done, a_pass, a_mode;
    logic [25:0] a_in;
    logic [13:0] a_out;
    logic [15:0] a_sig;
    assign a_out = a_mode ? bench_f(a_in, 1'b0) : 14'h0;

    bench_bist_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .abort(a_abort),
        .dut_in(a_in), .dut_out(a_out), .busy(a_busy), .done(a_done),
        .pass(a_pass), .signature(a_sig)
    );

    // ---------------- instance B: single pattern ----------------
    logic        b_start, b_abort, b_busy, b_done, b_pass;
    logic [25:0] b_in;
    logic [13:0] b_out;
    logic [15:0] b_sig;
    assign b_out = b_in[13:0];

    bench_bist_ctrl #(.PATTERNS(1), .SEED(32'h1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .dut_in(b_in), .dut_out(b_out), .busy(b_busy), .done(b_done),
        .pass(b_pass), .signature(b_sig)
    );

    // ---------------- instance G: golden compare ----------------
    // SEED 0x101, 3 patterns: vectors 0x101, 0x203, 0x406 -> sig 0x0404.
    // With f8 stuck low: vectors 0x001, 0x203, 0x406 -> sig 0x0004.
    logic        g_start, g_abort, g_busy, g_done, g_pass, g_stuck;
    logic [25:0] g_in;
    logic [13:0] g_out;
    logic [15:0] g_sig;
    assign g_out = bench_f(g_in, g_stuck);

    bench_bist_ctrl #(.PATTERNS(3), .SEED(32'h0000_0101), .GOLDEN(16'h0404)) u_g (
        .clk(clk), .rst_n(rst_n), .start(g_start), .abort(g_abort),
        .dut_in(g_in), .dut_out(g_out), .busy(g_busy), .done(g_done),
        .pass(g_pass), .signature(g_sig)
    );

    // ---------------- instance C: zero seed ----------------
    logic        c_start, c_abort, c_busy, c_done, c_pass;
    logic [25:0] c_in;
    logic [13:0] c_out;
    logic [15:0] c_sig;
    assign c_out = c_in[13:0];

    bench_bist_ctrl #(.SEED(32'h0)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .abort(c_abort),
        .dut_in(c_in), .dut_out(c_out), .busy(c_busy), .done(c_done),
        .pass(c_pass), .signature(c_sig)
    );

    // Pulse start on A and wait (bounded) for done. lat counts cycles from the
    // start cycle; first_* are the outputs seen one cycle after start.
    task automatic run_a(output int lat, output int busy_cnt,
                         output logic first_busy, output logic first_done);
        lat = -1; busy_cnt = 0; first_busy = 1'b0; first_done = 1'b0;
        a_start = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            a_start = 1'b0;
            if (k == 1) begin first_busy = a_busy; first_done = a_done; end
            if (a_busy) busy_cnt++;
            if (a_done) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_start = 0; a_abort = 0; a_mode = 0;
        b_start = 0; b_abort = 0;
        g_start = 0; g_abort = 0; g_stuck = 0;
        c_start = 0; c_abort = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", a_busy); else n_pass++;
        n_checks++; if (a_done !== 1'b0) $display("FAIL reset_done got %b want 0", a_done); else n_pass++;
        n_checks++; if (a_pass !== 1'b0) $display("FAIL reset_pass got %b want 0", a_pass); else n_pass++;
        n_checks++; if (a_sig !== 16'h0) $display("FAIL reset_sig got %h want 0000", a_sig); else n_pass++;
        n_checks++; if (a_in !== 26'h0) $display("FAIL reset_dut_in got %h want 0", a_in); else n_pass++;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0 || a_in !== 26'h0 || a_done !== 1'b0)
            $display("FAIL idle_hold busy=%b done=%b dut_in=%h want 0/0/0", a_busy, a_done, a_in);
        else n_pass++;
    endtask

    task automatic test_zero_run();
        int lat, bc;
        logic fb, fd;
        a_mode = 1'b0;
        run_a(lat, bc, fb, fd);
        n_checks++; if (lat != 1026) $display("FAIL zero_latency got %0d want 1026", lat); else n_pass++;
        n_checks++; if (bc != 1025) $display("FAIL zero_busy_cycles got %0d want 1025", bc); else n_pass++;
        n_checks++; if (a_sig !== 16'h0) $display("FAIL zero_sig got %h want 0000", a_sig); else n_pass++;
        n_checks++; if (a_pass !== 1'b1) $display("FAIL zero_pass got %b want 1", a_pass); else n_pass++;
        n_checks++; if (a_busy !== 1'b0) $display("FAIL zero_busy_at_done got %b want 0", a_busy); else n_pass++;
        repeat (5) @(negedge clk);
        n_checks++;
        if (a_done !== 1'b1 || a_pass !== 1'b1)
            $display("FAIL done_hold done=%b pass=%b want 1/1", a_done, a_pass);
        else n_pass++;
    endtask

    task automatic test_benchmark_rerun();
        int lat, bc;
        logic fb, fd;
        logic [15:0] exp;
        exp = model_sig(32'h1, 1024, 1);
        a_mode = 1'b1;
        run_a(lat, bc, fb, fd);   // starts from DONE
        n_checks++;
        if (fb !== 1'b1 || fd !== 1'b0)
            $display("FAIL rerun_load busy=%b done=%b want 1/0", fb, fd);
        else n_pass++;
        n_checks++; if (lat != 1026) $display("FAIL bench_latency got %0d want 1026", lat); else n_pass++;
        n_checks++; if (a_sig !== exp) $display("FAIL bench_sig got %h want %h", a_sig, exp); else n_pass++;
        n_checks++;
        if (a_pass !== (exp == 16'h0)) $display("FAIL bench_pass got %b want %b", a_pass, (exp == 16'h0));
        else n_pass++;
    endtask

    task automatic test_abort();
        int lat, bc;
        logic fb, fd;
        logic [15:0] exp_part;
        logic [31:0] exp_l;
        exp_part = model_sig(32'h1, 99, 1);
        exp_l    = model_lfsr(32'h1, 99);
        a_mode  = 1'b1;
        a_start = 1'b1;
        @(negedge clk);             // LOAD
        a_start = 1'b0;
        repeat (100) @(negedge clk); // now in RUN cycle 100
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        n_checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0)
            $display("FAIL abort_outputs busy=%b done=%b pass=%b want 0/0/0", a_busy, a_done, a_pass);
        else n_pass++;
        n_checks++; if (a_sig !== exp_part) $display("FAIL abort_sig got %h want %h", a_sig, exp_part); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_sig !== exp_part || a_in !== exp_l[25:0])
            $display("FAIL abort_freeze sig=%h dut_in=%h want %h/%h", a_sig, a_in, exp_part, exp_l[25:0]);
        else n_pass++;
        run_a(lat, bc, fb, fd);
        n_checks++;
        if (lat != 1026 || a_sig !== model_sig(32'h1, 1024, 1))
            $display("FAIL abort_rerun lat=%0d sig=%h want 1026/%h", lat, a_sig, model_sig(32'h1, 1024, 1));
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int lat, bc;
        logic fb, fd;
        a_mode  = 1'b1;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_pass !== 1'b0 || a_sig !== 16'h0 || a_in !== 26'h0)
            $display("FAIL midrun_reset busy=%b done=%b pass=%b sig=%h dut_in=%h want all 0",
                     a_busy, a_done, a_pass, a_sig, a_in);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL midrun_no_done done=%b busy=%b want 0/0", a_done, a_busy);
        else n_pass++;
        run_a(lat, bc, fb, fd);
        n_checks++;
        if (a_sig !== model_sig(32'h1, 1024, 1))
            $display("FAIL reset_rerun_sig got %h want %h", a_sig, model_sig(32'h1, 1024, 1));
        else n_pass++;
    endtask

    task automatic test_single();
        int lat;
        logic [25:0] run_in;
        lat = -1; run_in = '1;
        b_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            b_start = 1'b0;
            if (k == 2) run_in = b_in;
            if (b_done) begin lat = k; break; end
        end
        n_checks++; if (lat != 3) $display("FAIL single_latency got %0d want 3", lat); else n_pass++;
        n_checks++; if (run_in !== 26'h1) $display("FAIL single_vector got %h want 1", run_in); else n_pass++;
        n_checks++; if (b_sig !== 16'h0001) $display("FAIL single_sig got %h want 0001", b_sig); else n_pass++;
        n_checks++; if (b_pass !== 1'b0) $display("FAIL single_pass got %b want 0", b_pass); else n_pass++;
    endtask

    task automatic run_g(output int lat);
        lat = -1;
        g_start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            g_start = 1'b0;
            if (g_done) begin lat = k; break; end
        end
    endtask

    task automatic test_golden();
        int lat;
        g_stuck = 1'b0;
        run_g(lat);
        n_checks++; if (lat != 5) $display("FAIL golden_latency got %0d want 5", lat); else n_pass++;
        n_checks++; if (g_sig !== 16'h0404) $display("FAIL golden_sig got %h want 0404", g_sig); else n_pass++;
        n_checks++; if (g_pass !== 1'b1) $display("FAIL golden_pass got %b want 1", g_pass); else n_pass++;
        g_stuck = 1'b1;
        run_g(lat);
        n_checks++; if (g_sig !== 16'h0004) $display("FAIL stuck_sig got %h want 0004", g_sig); else n_pass++;
        n_checks++; if (g_pass !== 1'b0) $display("FAIL stuck_pass got %b want 0", g_pass); else n_pass++;
        g_stuck = 1'b0;
    endtask

    task automatic test_seed_zero();
        int lat, errs;
        logic [31:0] l;
        logic [25:0] first_in;
        lat = -1; errs = 0; l = 32'h1; first_in = '1;
        c_start = 1'b1;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            c_start = 1'b0;
            if (c_done) begin lat = k; break; end
            if (k >= 2) begin
                if (k == 2) first_in = c_in;
                if (c_in !== l[25:0]) errs++;
                l = {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
            end
        end
        n_checks++; if (first_in !== 26'h1) $display("FAIL seed0_first got %h want 1", first_in); else n_pass++;
        n_checks++; if (errs != 0) $display("FAIL seed0_sequence got %0d bad vectors want 0", errs); else n_pass++;
        n_checks++; if (lat != 1026) $display("FAIL seed0_latency got %0d want 1026", lat); else n_pass++;
        n_checks++;
        if (c_sig !== model_sig(32'h0, 1024, 2))
            $display("FAIL seed0_sig got %h want %h", c_sig, model_sig(32'h0, 1024, 2));
        else n_pass++;
    endtask

    task automatic test_start_abort();
        // From DONE: abort wins, instance returns to IDLE.
        c_start = 1'b1; c_abort = 1'b1;
        @(negedge clk);
        c_start = 1'b0; c_abort = 1'b0;
        n_checks++;
        if (c_busy !== 1'b0 || c_done !== 1'b0 || c_pass !== 1'b0)
            $display("FAIL start_abort_done busy=%b done=%b pass=%b want 0/0/0", c_busy, c_done, c_pass);
        else n_pass++;
        // From IDLE: still idle.
        c_start = 1'b1; c_abort = 1'b1;
        @(negedge clk);
        c_start = 1'b0; c_abort = 1'b0;
        @(negedge clk);
        n_checks++;
        if (c_busy !== 1'b0 || c_done !== 1'b0)
            $display("FAIL start_abort_idle busy=%b done=%b want 0/0", c_busy, c_done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero_run();
        test_benchmark_rerun();
        test_abort();
        test_reset_mid_run();
        test_single();
        test_golden();
        test_seed_zero();
        test_start_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
